switch_debounce: RTL

Conditions the 16 raw board switch inputs before they reach the switch I/O slave's `switches` input. Each bit is synchronised to the system clock, then sampled at a slow prescaled tick. A bit's output changes only after the input has been stable for a configurable number of consecutive ticks. Also emits a one-cycle change strobe for polling or interrupt logic.

---
 rtl/switch_debounce_pkg.sv | 16 +
 rtl/switch_debounce_if.sv | 38 +++
 rtl/switch_debounce_bit.sv | 47 ++++
 rtl/switch_debounce.sv | 81 ++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared switch I/O definitions: width, default timing and the switch word type.
// Latency: n/a (package). Backpressure: n/a.
package io_pkg;

   localparam int SWITCH_WIDTH           = 16;
   localparam int DEFAULT_TICK_DIV       = 50000;
   localparam int DEFAULT_STABLE_SAMPLES = 4;

   typedef logic [SWITCH_WIDTH-1:0] switch_word_t;

   // A divide-by-one prescaler still needs a one-bit counter to stay legal.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced levels and strobes out (IRQ pair under SWITCH_IRQ_EN).
// Latency: n/a (wires only). Backpressure: none, outputs are level/strobe signals.
interface switch_debounce_if
   import io_pkg::*;
#(
   parameter int WIDTH = SWITCH_WIDTH
);

   logic [WIDTH-1:0] raw_switches;
   logic [WIDTH-1:0] switches;
   logic             changed;
   logic             sample_tick;
`ifdef SWITCH_IRQ_EN
   logic             irq_clear;
   logic             nIRQ;

   modport master (
      output raw_switches, irq_clear,
      input  switches, changed, sample_tick, nIRQ
   );

   modport slave (
      input  raw_switches, irq_clear,
      output switches, changed, sample_tick, nIRQ
   );
`else
   modport master (
      output raw_switches,
      input  switches, changed, sample_tick
   );

   modport slave (
      input  raw_switches,
      output switches, changed, sample_tick
   );
`endif

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-sampled history and accept/hold decision.
// Latency: 2 clocks sync + STABLE_SAMPLES ticks. Backpressure: none.
module debounce_bit #(
   parameter int STABLE_SAMPLES = 4
) (
   input  logic Clock,
   input  logic nReset,
   input  logic raw,
   input  logic sample,
   output logic level,
   output logic level_nxt
);

   logic                      sync1;
   logic                      sync2;
   logic [STABLE_SAMPLES-1:0] hist;
   logic [STABLE_SAMPLES-1:0] hist_nxt;

   // The decision looks at the history as it will be after this edge's shift.
   always_comb begin
      hist_nxt  = hist;
      level_nxt = level;
      if (sample) begin
         hist_nxt = {hist[STABLE_SAMPLES-2:0], sync2};
         if (&hist_nxt) begin
            level_nxt = 1'b1;
         end else if (~|hist_nxt) begin
            level_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         hist  <= hist_nxt;
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH switch pins with one shared sample prescaler; optional sticky IRQ under SWITCH_IRQ_EN.
// Latency: 2 + up to STABLE_SAMPLES*TICK_DIV + 1 clocks. Backpressure: none, levels are always driven.
module switch_debounce
   import io_pkg::*;
#(
   parameter int WIDTH          = SWITCH_WIDTH,
   parameter int TICK_DIV       = DEFAULT_TICK_DIV,
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic        Clock,
   input  logic        nReset,
   switch_debounce_if.slave bus
);

   localparam int CW = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0]    tick_cnt;
   logic             tick;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_nxt;
   logic             changed_q;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick <= (tick_cnt == CNT_LAST);
         if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_bit (
         .Clock    (Clock),
         .nReset   (nReset),
         .raw      (bus.raw_switches[i]),
         .sample   (tick),
         .level    (level[i]),
         .level_nxt(level_nxt[i])
      );
   end

   // Any number of bits flipping on the same edge yields a single strobe.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= |(level_nxt ^ level);
      end
   end

   assign bus.switches    = level;
   assign bus.changed     = changed_q;
   assign bus.sample_tick = tick;

`ifdef SWITCH_IRQ_EN
   logic nirq_q;

   // Stored inverted so the flop drives the active-low pin directly; a new change beats a clear.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         nirq_q <= 1'b1;
      end else if (changed_q) begin
         nirq_q <= 1'b0;
      end else if (bus.irq_clear) begin
         nirq_q <= 1'b1;
      end
   end

   assign bus.nIRQ = nirq_q;
`endif

endmodule
